// File: rtl/dmem_if.sv
// Load/store bus between the CPU data port (master) and a data-memory target (slave).
// Request and response each use their own valid/ready handshake.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory target: one request at a time, registered response outputs.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic   clk,
    input  logic   reset_n,
    dmem_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        cap_write;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    logic        req_ready_nxt;
    logic        resp_valid_nxt;
    logic [31:0] resp_rdata_nxt;
    logic        resp_err_nxt;

    logic [31:0] mem [DEPTH];

    logic          accept;
    logic          access;
    logic          addr_err;
    logic          mem_we;
    logic [AW-1:0] idx;

    assign accept   = (state == IDLE) && bus.req_valid && bus.req_ready;
    // The first RESP cycle (resp_valid still low) is where the array is touched.
    assign access   = (state == RESP) && !bus.resp_valid;
    assign addr_err = (cap_addr[1:0] != 2'b00) || (cap_addr[31:AW+2] != '0);
    assign idx      = cap_addr[AW+1:2];
    assign mem_we   = access && cap_write && !addr_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            cap_write      <= 1'b0;
            cap_addr       <= '0;
            cap_wdata      <= '0;
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            bus.req_ready  <= req_ready_nxt;
            bus.resp_valid <= resp_valid_nxt;
            bus.resp_rdata <= resp_rdata_nxt;
            bus.resp_err   <= resp_err_nxt;
            if (accept) begin
                cap_write <= bus.req_write;
                cap_addr  <= bus.req_addr;
                cap_wdata <= bus.req_wdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nxt   = 4'(LATENCY - 1);
                    state_nxt = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) state_nxt = RESP;
            end
            RESP: begin
                if (bus.resp_valid && bus.resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready_nxt  = (state_nxt == IDLE);
        resp_valid_nxt = bus.resp_valid;
        resp_rdata_nxt = bus.resp_rdata;
        resp_err_nxt   = bus.resp_err;
        if (access) begin
            resp_valid_nxt = 1'b1;
            resp_err_nxt   = addr_err;
            resp_rdata_nxt = (!cap_write && !addr_err) ? mem[idx] : 32'd0;
        end else if (state == RESP && bus.resp_valid && bus.resp_ready) begin
            resp_valid_nxt = 1'b0;
            resp_rdata_nxt = 32'd0;
            resp_err_nxt   = 1'b0;
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= cap_wdata;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (LATENCY 2, 1, 3) share one stimulus,
// one is selected at a time for checking.
module tb_dmem_responder;
    localparam int DEPTH = 256;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        reset_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_ready = 1'b1;

    int sel = 0;
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int prev_acc = 0;
    bit have_prev = 0;
    bit gap_chk = 0;
    bit prev_rv = 0;

    exp_t        q[$];
    logic [31:0] model [int];

    dmem_if if1 ();
    dmem_if if2 ();
    dmem_if if3 ();

    assign if1.req_valid = req_valid;  assign if2.req_valid = req_valid;  assign if3.req_valid = req_valid;
    assign if1.req_write = req_write;  assign if2.req_write = req_write;  assign if3.req_write = req_write;
    assign if1.req_addr  = req_addr;   assign if2.req_addr  = req_addr;   assign if3.req_addr  = req_addr;
    assign if1.req_wdata = req_wdata;  assign if2.req_wdata = req_wdata;  assign if3.req_wdata = req_wdata;
    assign if1.resp_ready = resp_ready; assign if2.resp_ready = resp_ready; assign if3.resp_ready = resp_ready;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut2 (.clk(clk), .reset_n(reset_n), .bus(if2));
    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));
    dmem_responder #(.DEPTH(DEPTH), .LATENCY(3)) u_dut3 (.clk(clk), .reset_n(reset_n), .bus(if3));

    logic        c_req_ready, c_resp_valid, c_resp_err;
    logic [31:0] c_resp_rdata;
    int          cur_lat;

    assign c_req_ready  = (sel == 0) ? if2.req_ready  : (sel == 1) ? if1.req_ready  : if3.req_ready;
    assign c_resp_valid = (sel == 0) ? if2.resp_valid : (sel == 1) ? if1.resp_valid : if3.resp_valid;
    assign c_resp_rdata = (sel == 0) ? if2.resp_rdata : (sel == 1) ? if1.resp_rdata : if3.resp_rdata;
    assign c_resp_err   = (sel == 0) ? if2.resp_err   : (sel == 1) ? if1.resp_err   : if3.resp_err;
    assign cur_lat      = (sel == 0) ? 2 : (sel == 1) ? 1 : 3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge what the next rising edge will do.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (req_valid && c_req_ready) begin
                check("accept_no_resp", {31'd0, c_resp_valid}, 32'd0);
                if (gap_chk && have_prev) check("accept_gap", cyc + 1 - prev_acc, cur_lat + 2);
                prev_acc  = cyc + 1;
                have_prev = 1;
                acc_cyc   = cyc + 1;
            end
            if (c_resp_valid && !prev_rv) check("latency", cyc - acc_cyc, cur_lat);
            if (c_resp_valid && resp_ready) begin
                if (q.size() == 0) begin
                    check("sb_unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("resp_rdata", c_resp_rdata, e.rdata);
                    check("resp_err", {31'd0, c_resp_err}, {31'd0, e.err});
                end
            end
            prev_rv = c_resp_valid;
        end else begin
            prev_rv = 0;
        end
    end

    task automatic do_reset;
        reset_n = 1'b0;
        req_valid = 1'b0;
        q.delete();
        have_prev = 0;
        #1;
        check("rst_req_ready", {31'd0, c_req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, c_resp_valid}, 32'd0);
        check("rst_resp_rdata", c_resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, c_resp_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        check("rdy_before_edge", {31'd0, c_req_ready}, 32'd0);
        @(posedge clk);
        #1 check("rdy_after_rst", {31'd0, c_req_ready}, 32'd1);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input bit wr, input logic [31:0] addr, input logic [31:0] wdata, input bit keep);
        exp_t e;
        bit   bad;
        bit   ok;
        bad = (addr[1:0] != 2'b00) || (addr >= 32'(DEPTH * 4));
        e.err   = bad;
        e.rdata = (!wr && !bad) ? model[int'(addr >> 2)] : 32'd0;
        if (wr && !bad) model[int'(addr >> 2)] = wdata;
        q.push_back(e);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (c_req_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic drain;
        bit ok;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0 && !c_resp_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit ok;
        #2;
        // LATENCY = 2 instance
        sel = 0;
        do_reset();
        send(1, 32'h0,  32'h1111_1111, 0); drain();
        send(1, 32'h10, 32'hDEAD_BEEF, 0); drain();
        send(0, 32'h10, 32'h0, 0);         drain();
        send(0, 32'h13, 32'h0, 0);         drain();
        send(1, 32'h400, 32'h5555_AAAA, 0); drain();
        send(0, 32'h0,  32'h0, 0);         drain();

        // Stalled response
        resp_ready = 1'b0;
        send(0, 32'h10, 32'h0, 0);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (c_resp_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("stall_resp_timeout", 32'd0, 32'd1);
        repeat (5) begin
            check("stall_valid", {31'd0, c_resp_valid}, 32'd1);
            check("stall_rdata", c_resp_rdata, 32'hDEAD_BEEF);
            check("stall_err", {31'd0, c_resp_err}, 32'd0);
            check("stall_req_ready", {31'd0, c_req_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        @(posedge clk);
        #1 check("ready_after_hs", {31'd0, c_req_ready}, 32'd1);
        check("valid_after_hs", {31'd0, c_resp_valid}, 32'd0);

        // Request inputs wiggled while the store is in flight
        send(1, 32'h34, 32'h3434_3434, 0); drain();
        send(1, 32'h30, 32'hC0FF_EE00, 0);
        req_write = 1'b1;
        req_addr  = 32'h34;
        req_wdata = 32'hBAD0_BAD0;
        drain();
        send(0, 32'h30, 32'h0, 0); drain();
        send(0, 32'h34, 32'h0, 0); drain();

        // LATENCY = 1 instance, back-to-back loads with req_valid held
        sel = 1;
        model.delete();
        do_reset();
        send(1, 32'h40, 32'h4040_0001, 0); drain();
        send(1, 32'h44, 32'h4444_0002, 0); drain();
        send(1, 32'h48, 32'h4848_0003, 0); drain();
        gap_chk = 1;
        have_prev = 0;
        send(0, 32'h40, 32'h0, 1);
        send(0, 32'h44, 32'h0, 1);
        send(0, 32'h48, 32'h0, 0);
        drain();
        gap_chk = 0;

        // LATENCY = 3 instance, reset during an in-flight store
        sel = 2;
        model.delete();
        do_reset();
        send(1, 32'h20, 32'hAAAA_5555, 0); drain();
        send(1, 32'h20, 32'h1234_5678, 0);
        model[32'h20 >> 2] = 32'hAAAA_5555;
        @(posedge clk);
        #1 do_reset();
        send(0, 32'h20, 32'h0, 0); drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
